painterengine_gpu_reader_arbiter: RTL and testbench
===================================================

// Module: painterengine_gpu_reader_arbiter
// PURPOSE
//  Shares the single GPU DMA reader between two requesters: port 0 (display fetch, high priority) and port 1 (blitter/texture fetch).
//  Sequences the reader's resetn-based protocol: closes it, loads address/length, opens it, waits for done/error, then closes it again.
//  Routes the reader data stream only to the owner.
//  Fixed priority to port 0, with a starvation guard so port 1 always progresses.
// PARAMETERS
//  STARVE_LIMIT   8    consecutive port-0 grants while port 1 is pending before port 1 is forced a grant (1..255)
//  TIMEOUT_CYCLES 4096 busy-cycle limit of the watchdog (only with PE_GPU_READER_ARB_TIMEOUT_EN)
// PORTS
//  i_wire_clock               in   1   single clock for all logic
//  i_wire_reset               in   1   synchronous, active-high reset
//  i_wire_req{0,1}            in   1   request level; held high with stable address/length until that port's done/error pulse
//  i_wire_req{0,1}_address    in   32  byte address of the burst
//  i_wire_req{0,1}_length     in   32  burst length in 32-bit words
//  o_wire_grant{0,1}          out  1   port currently owns the reader (ISSUE..RELEASE)
//  o_wire_done{0,1}           out  1   one-cycle pulse: burst completed
//  o_wire_error{0,1}          out  1   one-cycle pulse: burst aborted on reader error or timeout
//  o_wire_data_valid{0,1}     out  1   i_wire_reader_data_valid gated by ownership
//  i_wire_data_next{0,1}      in   1   port can accept data; only the owner's value is forwarded
//  o_wire_data                out  32  i_wire_reader_data, passed through
//  o_wire_reader_address      out  32  to DMA reader
//  o_wire_reader_length       out  32  to DMA reader
//  o_wire_reader_resetn       out  1   0 = reader closed/cleared, 1 = reader running
//  i_wire_reader_done         in   1   level; held until reader_resetn falls
//  i_wire_reader_error        in   1   level; held until reader_resetn falls
//  i_wire_reader_data         in   32
//  i_wire_reader_data_valid   in   1
//  o_wire_reader_data_next    out  1   owner's i_wire_data_next; 0 when no owner
//  o_wire_state               out  32  {24'd0, owner, starve_cnt[3:0], fsm[2:0]}
// BEHAVIOUR
//  Reset (sync, high): FSM=IDLE; all outputs 0, including reader_resetn=0, address/length=0 and starve_cnt=0.
//  Reset also aborts an in-flight burst silently, with no done/error pulse.
//  FSM states:
//   - IDLE: no request -> stay. Otherwise pick the owner:
//     - port 1 if req1 && (!req0 || starve_cnt==STARVE_LIMIT); else port 0.
//     - Latch the owner's address/length and go to ISSUE.
//   - ISSUE (1 cycle): reader_resetn=0 with address/length stable; grant asserted.
//     - length==0 -> RELEASE with done; else -> BUSY.
//   - BUSY: reader_resetn=1.
//     - error has priority over done when both are high in the same cycle -> RELEASE with error.
//     - done -> RELEASE with done.
//   - RELEASE (1 cycle): reader_resetn=0; pulse the owner's done or error; grant still high; -> IDLE.
//  Arbitration latency: req rises in IDLE -> grant is high the next cycle (ISSUE).
//   - Reader is opened 2 cycles after the request.
//  Requesters clear req on the edge where they sample the done/error pulse; IDLE then sees the updated level.
//  starve_cnt:
//   - Port-0 grant while req1 high -> +1, saturating at STARVE_LIMIT.
//   - Any port-1 grant, or a port-0 grant with req1 low -> 0.
//  Data path is combinational pass-through gated by owner and state BUSY.
//   - Non-owner data_valid=0.
//   - reader_data_next=0 outside BUSY.
//  Request changes (address/length) during ownership are ignored; the values latched in IDLE are used.
//  A request dropped mid-burst does not abort it; the burst runs to completion and the pulse is still issued.
//  Both requests arriving in the same cycle are resolved by the priority rule above.
// CONFIGURATION
//  `PE_GPU_READER_ARB_TIMEOUT_EN defined:
//   - 16-bit busy counter, cleared on entering BUSY.
//   - Reaching TIMEOUT_CYCLES in BUSY -> RELEASE with error, and sticky o_wire_state[15]=1.
//   - The sticky bit is cleared only by reset.
//  Undefined: no counter; BUSY waits indefinitely; o_wire_state[15]=0.
// STRUCTURE
//  Package painterengine_gpu_pkg: FSM state encodings (ARB_IDLE/ISSUE/BUSY/RELEASE) and the reader burst-size constant (64).
//  One sub-module, painterengine_gpu_arb_select: combinational priority + starvation pick; holds no state.
//  The FSM, latches and datapath gating stay in the top module.
// TESTING
//  - Single req0, addr 0x1000, len 64; reader done after 70 cycles -> grant0 on cycle 1, reader_resetn high cycles 2..71, done0 pulse 1 cycle, reader_resetn=0 during RELEASE.
//  - req0 and req1 rise together -> port 0 first; port 1 granted in the IDLE cycle after port 0's RELEASE.
//  - req0 held continuously, req1 pending, STARVE_LIMIT=8 -> 8 port-0 grants, then port 1, then starve_cnt=0.
//  - Reader done and error high in the same cycle -> error pulse only; req1, len 0 -> done1 with reader_resetn never high.
//  - Reset asserted mid-BUSY -> next cycle all outputs 0, no pulse; with TIMEOUT_EN, TIMEOUT_CYCLES=100 and no reader done -> error0 after 100 BUSY cycles, state[15]=1.

Source files
------------

// File: rtl/painterengine_gpu_pkg.sv
// Shared types and constants for the PainterEngine GPU reader arbiter.
package painterengine_gpu_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE    = 3'd0,
    ARB_ISSUE   = 3'd1,
    ARB_BUSY    = 3'd2,
    ARB_RELEASE = 3'd3
  } arb_state_t;

  localparam int unsigned READER_BURST_WORDS = 64;

endpackage

// File: rtl/painterengine_gpu_arb_select.sv
// Stateless owner pick: port 0 wins unless port 1 is alone or has starved.
module painterengine_gpu_arb_select #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic       i_wire_req0,
  input  logic       i_wire_req1,
  input  logic [7:0] i_wire_starve_cnt,
  output logic       o_wire_pick_valid,
  output logic       o_wire_pick_port
);

  assign o_wire_pick_valid = i_wire_req0 | i_wire_req1;
  assign o_wire_pick_port  = i_wire_req1 &
                             (~i_wire_req0 | (i_wire_starve_cnt == 8'(STARVE_LIMIT)));

endmodule

// File: rtl/painterengine_gpu_reader_arbiter.sv
// Two-port arbiter and resetn-protocol sequencer for the shared GPU DMA reader.
// Optional busy watchdog enabled by defining PE_GPU_READER_ARB_TIMEOUT_EN.
//
// state       | meaning
// ARB_IDLE    | no owner, picking the next requester
// ARB_ISSUE   | reader held closed while address/length settle
// ARB_BUSY    | reader open, waiting for done/error
// ARB_RELEASE | reader closed again, owner gets its done/error pulse
module painterengine_gpu_reader_arbiter
  import painterengine_gpu_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT   = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        i_wire_clock,
  input  logic        i_wire_reset,
  input  logic        i_wire_req0,
  input  logic [31:0] i_wire_req0_address,
  input  logic [31:0] i_wire_req0_length,
  input  logic        i_wire_req1,
  input  logic [31:0] i_wire_req1_address,
  input  logic [31:0] i_wire_req1_length,
  output logic        o_wire_grant0,
  output logic        o_wire_grant1,
  output logic        o_wire_done0,
  output logic        o_wire_done1,
  output logic        o_wire_error0,
  output logic        o_wire_error1,
  output logic        o_wire_data_valid0,
  output logic        o_wire_data_valid1,
  input  logic        i_wire_data_next0,
  input  logic        i_wire_data_next1,
  output logic [31:0] o_wire_data,
  output logic [31:0] o_wire_reader_address,
  output logic [31:0] o_wire_reader_length,
  output logic        o_wire_reader_resetn,
  input  logic        i_wire_reader_done,
  input  logic        i_wire_reader_error,
  input  logic [31:0] i_wire_reader_data,
  input  logic        i_wire_reader_data_valid,
  output logic        o_wire_reader_data_next,
  output logic [31:0] o_wire_state
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_starve_limit
    $error("STARVE_LIMIT must be within 1..255");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit the 16-bit busy counter");
  end

  arb_state_t  state_q, state_nxt;
  logic        rel_err_q, rel_err_nxt;
  logic        owner_q;
  logic [31:0] addr_q, len_q;
  logic [7:0]  starve_q;
  logic        pick_valid, pick_port;
  logic        timeout_hit;
  logic        timeout_sticky;

  painterengine_gpu_arb_select #(.STARVE_LIMIT(STARVE_LIMIT)) u_select (
    .i_wire_req0       (i_wire_req0),
    .i_wire_req1       (i_wire_req1),
    .i_wire_starve_cnt (starve_q),
    .o_wire_pick_valid (pick_valid),
    .o_wire_pick_port  (pick_port)
  );

`ifdef PE_GPU_READER_ARB_TIMEOUT_EN
  logic [15:0] busy_cnt_q;

  assign timeout_hit    = (state_q == ARB_BUSY) && (busy_cnt_q == 16'(TIMEOUT_CYCLES - 1));

  // Counter sits at zero outside BUSY, so it restarts on every BUSY entry.
  always_ff @(posedge i_wire_clock) begin
    if (i_wire_reset) begin
      busy_cnt_q     <= 16'd0;
      timeout_sticky <= 1'b0;
    end else begin
      busy_cnt_q <= (state_q == ARB_BUSY) ? busy_cnt_q + 16'd1 : 16'd0;
      if (timeout_hit) timeout_sticky <= 1'b1;
    end
  end
`else
  assign timeout_hit    = 1'b0;
  assign timeout_sticky = 1'b0;
`endif

  always_comb begin
    state_nxt   = state_q;
    rel_err_nxt = rel_err_q;
    case (state_q)
      ARB_IDLE: if (pick_valid) state_nxt = ARB_ISSUE;
      ARB_ISSUE: begin
        if (len_q == 32'd0) begin
          state_nxt   = ARB_RELEASE;
          rel_err_nxt = 1'b0;
        end else begin
          state_nxt = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (i_wire_reader_error || timeout_hit) begin
          state_nxt   = ARB_RELEASE;
          rel_err_nxt = 1'b1;
        end else if (i_wire_reader_done) begin
          state_nxt   = ARB_RELEASE;
          rel_err_nxt = 1'b0;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_wire_clock) begin
    if (i_wire_reset) begin
      state_q   <= ARB_IDLE;
      rel_err_q <= 1'b0;
      owner_q   <= 1'b0;
      addr_q    <= 32'd0;
      len_q     <= 32'd0;
      starve_q  <= 8'd0;
    end else begin
      state_q   <= state_nxt;
      rel_err_q <= rel_err_nxt;
      if (state_q == ARB_IDLE && pick_valid) begin
        owner_q <= pick_port;
        addr_q  <= pick_port ? i_wire_req1_address : i_wire_req0_address;
        len_q   <= pick_port ? i_wire_req1_length  : i_wire_req0_length;
        if (!pick_port && i_wire_req1) begin
          if (starve_q != 8'(STARVE_LIMIT)) starve_q <= starve_q + 8'd1;
        end else begin
          starve_q <= 8'd0;
        end
      end
    end
  end

  logic active, busy, release_now;
  assign active      = (state_q != ARB_IDLE);
  assign busy        = (state_q == ARB_BUSY);
  assign release_now = (state_q == ARB_RELEASE);

  assign o_wire_grant0 = active & ~owner_q;
  assign o_wire_grant1 = active &  owner_q;
  assign o_wire_done0  = release_now & ~rel_err_q & ~owner_q;
  assign o_wire_done1  = release_now & ~rel_err_q &  owner_q;
  assign o_wire_error0 = release_now &  rel_err_q & ~owner_q;
  assign o_wire_error1 = release_now &  rel_err_q &  owner_q;

  assign o_wire_reader_resetn  = busy;
  assign o_wire_reader_address = addr_q;
  assign o_wire_reader_length  = len_q;

  assign o_wire_data             = i_wire_reader_data;
  assign o_wire_data_valid0      = i_wire_reader_data_valid & busy & ~owner_q;
  assign o_wire_data_valid1      = i_wire_reader_data_valid & busy &  owner_q;
  assign o_wire_reader_data_next = busy & (owner_q ? i_wire_data_next1 : i_wire_data_next0);

  assign o_wire_state = {16'd0, timeout_sticky, 7'd0, owner_q, starve_q[3:0], state_q};

endmodule

// File: tb/tb_painterengine_gpu_reader_arbiter.sv
// Directed bench for the GPU reader arbiter; pulses are checked against a scoreboard queue.
module tb_painterengine_gpu_reader_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] a0 = '0, l0 = '0, a1 = '0, l1 = '0;
  logic        grant0, grant1, done0, done1, err0, err1, dv0, dv1;
  logic        next0 = 1'b0, next1 = 1'b0;
  logic [31:0] data_o, rd_addr, rd_len, state;
  logic        rd_resetn, rd_done, rd_err, rd_next;
  logic [31:0] rdata = '0;
  logic        rvalid = 1'b0;

  int rd_cnt = 0;
  int done_after = 0;
  int err_after = 0;
  int n_assert = 0;
  int n_fail = 0;
  logic [3:0] sb[$];

  localparam logic [2:0] S_IDLE = 3'd0, S_ISSUE = 3'd1, S_BUSY = 3'd2, S_REL = 3'd3;

  always #5 clk = ~clk;

  // Reader model: done/error rise a fixed number of open cycles after resetn goes high.
  always @(posedge clk) rd_cnt <= rd_resetn ? rd_cnt + 1 : 0;
  assign rd_done = rd_resetn && (done_after != 0) && (rd_cnt >= done_after - 1);
  assign rd_err  = rd_resetn && (err_after  != 0) && (rd_cnt >= err_after  - 1);

  painterengine_gpu_reader_arbiter #(.STARVE_LIMIT(8), .TIMEOUT_CYCLES(100)) dut (
    .i_wire_clock             (clk),
    .i_wire_reset             (rst),
    .i_wire_req0              (req0),
    .i_wire_req0_address      (a0),
    .i_wire_req0_length       (l0),
    .i_wire_req1              (req1),
    .i_wire_req1_address      (a1),
    .i_wire_req1_length       (l1),
    .o_wire_grant0            (grant0),
    .o_wire_grant1            (grant1),
    .o_wire_done0             (done0),
    .o_wire_done1             (done1),
    .o_wire_error0            (err0),
    .o_wire_error1            (err1),
    .o_wire_data_valid0       (dv0),
    .o_wire_data_valid1       (dv1),
    .i_wire_data_next0        (next0),
    .i_wire_data_next1        (next1),
    .o_wire_data              (data_o),
    .o_wire_reader_address    (rd_addr),
    .o_wire_reader_length     (rd_len),
    .o_wire_reader_resetn     (rd_resetn),
    .i_wire_reader_done       (rd_done),
    .i_wire_reader_error      (rd_err),
    .i_wire_reader_data       (rdata),
    .i_wire_reader_data_valid (rvalid),
    .o_wire_reader_data_next  (rd_next),
    .o_wire_state             (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and score any done/error pulse.
  task automatic tick();
    logic [3:0] p;
    logic [3:0] e;
    @(negedge clk);
    p = {err1, done1, err0, done0};
    if (p != 4'd0) begin
      if (sb.size() == 0) chk("unexpected_pulse", {28'd0, p}, 32'd0);
      else begin
        e = sb.pop_front();
        chk("pulse", {28'd0, p}, {28'd0, e});
      end
    end
  endtask

  task automatic wait_fsm(input logic [2:0] s, input int max);
    int n = 0;
    while (state[2:0] !== s && n < max) begin
      tick();
      n++;
    end
    chk("wait_fsm", {29'd0, state[2:0]}, {29'd0, s});
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int hi;
    repeat (3) tick();
    chk("rst_state", state, 32'd0);
    chk("rst_resetn", {31'd0, rd_resetn}, 32'd0);
    chk("rst_grants", {30'd0, grant1, grant0}, 32'd0);
    chk("rst_addr", rd_addr, 32'd0);
    rst = 1'b0;
    tick();

    // Single port-0 burst, reader done after 70 open cycles.
    req0 = 1'b1; a0 = 32'h1000; l0 = 32'd64; done_after = 70;
    sb.push_back(4'b0001);
    tick();
    chk("t1_grant0", {31'd0, grant0}, 32'd1);
    chk("t1_issue_resetn", {31'd0, rd_resetn}, 32'd0);
    chk("t1_addr", rd_addr, 32'h1000);
    chk("t1_len", rd_len, 32'd64);
    tick();
    chk("t1_open", {31'd0, rd_resetn}, 32'd1);
    hi = 1;
    for (int i = 0; i < 200 && rd_resetn; i++) begin
      tick();
      if (rd_resetn) hi++;
    end
    chk("t1_open_cycles", 32'(hi), 32'd70);
    chk("t1_release", {29'd0, state[2:0]}, {29'd0, S_REL});
    chk("t1_done0", {31'd0, done0}, 32'd1);
    chk("t1_grant_rel", {31'd0, grant0}, 32'd1);
    req0 = 1'b0;
    tick();
    chk("t1_idle_grant", {31'd0, grant0}, 32'd0);

    // Simultaneous requests: port 0 first, then port 1 with data routing.
    done_after = 3;
    req0 = 1'b1; a0 = 32'h2000; l0 = 32'd4;
    req1 = 1'b1; a1 = 32'h3000; l1 = 32'd4;
    sb.push_back(4'b0001); sb.push_back(4'b0100);
    tick();
    chk("t2_grant", {30'd0, grant1, grant0}, 32'd1);
    chk("t2_starve1", {28'd0, state[6:3]}, 32'd1);
    wait_fsm(S_REL, 20);
    req0 = 1'b0;
    tick();
    chk("t2_idle", {29'd0, state[2:0]}, {29'd0, S_IDLE});
    rdata = 32'hABCD; rvalid = 1'b1; next1 = 1'b1; next0 = 1'b0;
    tick();
    chk("t2_grant1", {30'd0, grant1, grant0}, 32'd2);
    chk("t2_addr1", rd_addr, 32'h3000);
    chk("t2_starve0", {28'd0, state[6:3]}, 32'd0);
    chk("t2_next_issue", {31'd0, rd_next}, 32'd0);
    chk("t2_dv_issue", {30'd0, dv1, dv0}, 32'd0);
    a1 = 32'h4444;
    tick();
    chk("t2_dv_busy", {30'd0, dv1, dv0}, 32'd2);
    chk("t2_next_busy", {31'd0, rd_next}, 32'd1);
    chk("t2_data", data_o, 32'hABCD);
    chk("t2_addr_hold", rd_addr, 32'h3000);
    rvalid = 1'b0; next1 = 1'b0; rdata = '0;
    wait_fsm(S_REL, 20);
    req1 = 1'b0;
    tick();

    // Starvation guard: eight port-0 grants, then port 1.
    done_after = 1; l0 = 32'd1; l1 = 32'd1; req0 = 1'b1; req1 = 1'b1;
    repeat (8) sb.push_back(4'b0001);
    sb.push_back(4'b0100);
    for (int g = 1; g <= 8; g++) begin
      wait_fsm(S_ISSUE, 10);
      chk("t3_grant0", {31'd0, grant0}, 32'd1);
      chk("t3_starve", {28'd0, state[6:3]}, 32'(g));
      wait_fsm(S_REL, 10);
    end
    wait_fsm(S_ISSUE, 10);
    chk("t3_forced_grant1", {30'd0, grant1, grant0}, 32'd2);
    chk("t3_starve_clr", {28'd0, state[6:3]}, 32'd0);
    wait_fsm(S_REL, 10);
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // Done and error together: error wins.
    done_after = 5; err_after = 5; l0 = 32'd8; req0 = 1'b1;
    sb.push_back(4'b0010);
    wait_fsm(S_REL, 30);
    chk("t4_err_only", {30'd0, err0, done0}, 32'd2);
    req0 = 1'b0; done_after = 0; err_after = 0;
    tick();

    // Zero-length port-1 burst never opens the reader.
    req1 = 1'b1; l1 = 32'd0;
    sb.push_back(4'b0100);
    tick();
    chk("t5_issue", {29'd0, state[2:0]}, {29'd0, S_ISSUE});
    chk("t5_resetn_issue", {31'd0, rd_resetn}, 32'd0);
    tick();
    chk("t5_release", {29'd0, state[2:0]}, {29'd0, S_REL});
    chk("t5_resetn_rel", {31'd0, rd_resetn}, 32'd0);
    chk("t5_done1", {31'd0, done1}, 32'd1);
    req1 = 1'b0;
    tick();

    // Reset mid-BUSY aborts silently.
    l0 = 32'd16; req0 = 1'b1;
    wait_fsm(S_BUSY, 5);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("t6_state", state, 32'd0);
    chk("t6_outs", {26'd0, grant0, grant1, rd_resetn, done0, err0, rd_next}, 32'd0);
    chk("t6_addr", rd_addr, 32'd0);
    chk("t6_len", rd_len, 32'd0);
    rst = 1'b0; req0 = 1'b0;
    tick();
    chk("t6_idle", state, 32'd0);

`ifdef PE_GPU_READER_ARB_TIMEOUT_EN
    // Watchdog: reader never finishes, error after 100 busy cycles.
    l0 = 32'd16; req0 = 1'b1;
    sb.push_back(4'b0010);
    wait_fsm(S_BUSY, 5);
    hi = 1;
    for (int i = 0; i < 300 && state[2:0] == S_BUSY; i++) begin
      tick();
      if (state[2:0] == S_BUSY) hi++;
    end
    chk("t7_busy_cycles", 32'(hi), 32'd100);
    chk("t7_release", {29'd0, state[2:0]}, {29'd0, S_REL});
    chk("t7_sticky", {31'd0, state[15]}, 32'd1);
    req0 = 1'b0;
    tick();
    chk("t7_sticky_hold", {31'd0, state[15]}, 32'd1);
`else
    chk("t7_no_sticky", {31'd0, state[15]}, 32'd0);
`endif

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
